lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_GOOD, default 32: consecutive correct predictions needed to declare lock (range 1..255).
REQ-002 SHALL have parameter LOSS_BAD, default 4: consecutive mismatches while locked that force loss of lock (range 1..15).
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: in_bit is valid this cycle; at most one bit consumed per cycle.
REQ-006 SHALL have port in_bit, input, 1: received serial bit, taken as s[0] of the X^20+X^13+X^9+X^5+1 generator after each step.
REQ-007 SHALL have port clear_err, input, 1: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1: checker is in LOCKED state.
REQ-009 SHALL have port err_pulse, output, 1: one-cycle flag for a mismatched bit while LOCKED.
REQ-010 SHALL have port err_count, output, 16: saturating count of mismatches while LOCKED.
REQ-011 SHALL have port lock_lost, output, 1: one-cycle flag on the LOCKED->HUNT transition.

Function
REQ-012 SHALL hold a 20-bit register r; every shift is r <= {b, r[19:1]}, so r[0] is the oldest bit.
REQ-013 SHALL compute prediction p = r[15]^r[11]^r[7]^r[0], i.e. b[n+20] = b[n+15]^b[n+11]^b[n+7]^b[n].
REQ-014 SHALL implement states HUNT, VERIFY and LOCKED; no action occurs in a cycle with in_valid=0.
REQ-015 HUNT: shift in_bit into r and count fills; after the 20th valid bit go to VERIFY with the good count at 0.
REQ-016 VERIFY: compare in_bit with p and shift in_bit into r.
REQ-017 VERIFY, match: increment the good count; when it reaches LOCK_GOOD go to LOCKED.
REQ-018 VERIFY, mismatch: go to HUNT with the fill count at 0.
REQ-019 VERIFY: if r == 0 on any valid bit, go to HUNT (the all-zero state is degenerate).
REQ-020 LOCKED: shift p (flywheel), not in_bit, into r.
REQ-021 LOCKED, mismatch: assert err_pulse, increment err_count and increment the bad run.
REQ-022 LOCKED, match: clear the bad run.
REQ-023 LOCKED: when the bad run reaches LOSS_BAD, go to HUNT, pulse lock_lost and clear the fill count.
REQ-024 SHALL register all outputs; locked, err_pulse and lock_lost change in the cycle after the deciding valid bit.
REQ-025 err_count SHALL saturate at 16'hFFFF.
REQ-026 clear_err SHALL have priority: if asserted in the same cycle as a mismatch, err_count becomes 0; err_pulse still asserts.
REQ-027 err_count SHALL be held, not cleared, on loss of lock.

Reset
REQ-028 rst SHALL force state HUNT, r=0, all counters=0, locked=0, err_pulse=0, lock_lost=0 and err_count=0 on the next edge.
REQ-029 rst SHALL override all inputs, including reset asserted mid-operation in any state.

Structure
REQ-030 Package lfsr_pkg SHALL hold the LFSR width (20), the tap indices (15, 11, 7, 0) and the state enumeration.
REQ-031 SHALL be a single module with no sub-module; the prediction XOR is inline.

Verification
REQ-032 Stream from a reference generator seeded 20'h00001, in_valid=1 continuously: locked rises in cycle 20+32+1; err_count stays 0 over 10000 bits.
REQ-033 After lock, invert one bit: one err_pulse, err_count=1, locked stays 1, and the next bit matches again (flywheel).
REQ-034 After lock, invert 4 consecutive bits: err_count=4, lock_lost pulses once, locked=0; relock occurs after 52 further good bits.
REQ-035 Feed 40 zero bits from reset: the checker never leaves HUNT/VERIFY, locked=0, err_count=0.
REQ-036 Randomly deassert in_valid for 30% of cycles: same lock behaviour as REQ-032, counted in valid bits.
REQ-037 With err_count=5, assert clear_err together with a mismatch: err_count=0 and err_pulse=1; then assert rst mid-VERIFY: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Package for the PRBS-20 checker.
// Purpose: defines the LFSR width, the generator tap positions, the counter
// widths and the checker state enumeration shared by lfsr_checker.
// Ports: none (package).
package lfsr_pkg;

  // Generator X^20+X^13+X^9+X^5+1 seen from the receive window:
  // b[n+20] = b[n+15]^b[n+11]^b[n+7]^b[n].
  localparam int LFSR_W = 20;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 11;
  localparam int TAP_C  = 7;
  localparam int TAP_D  = 0;

  localparam int FILL_W = 5;
  localparam int GOOD_W = 8;
  localparam int BAD_W  = 4;
  localparam int CNT_W  = 16;

  // Fill count value on the last bit of the initial window load.
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_checker.sv
// PRBS-20 receive checker.
// Purpose: loads a 20-bit window from the received stream (HUNT), checks that
// the following bits follow the generator (VERIFY) and, once LOCK_GOOD
// consecutive predictions were correct, free-runs the local LFSR (LOCKED),
// counting mismatching received bits. LOSS_BAD consecutive mismatches drop
// back to HUNT.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - in_bit carries a received bit this cycle
//   in_bit     - received serial bit
//   clear_err  - synchronous clear of err_count (wins over an increment)
//   locked     - checker is in LOCKED state
//   err_pulse  - one-cycle flag for a mismatched bit while LOCKED
//   err_count  - saturating mismatch count while LOCKED
//   lock_lost  - one-cycle flag on the LOCKED->HUNT transition
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_GOOD = 32,
  parameter int LOSS_BAD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             lock_lost
);

  localparam logic [GOOD_W-1:0] LOCK_GOOD_C = GOOD_W'(LOCK_GOOD);
  localparam logic [BAD_W-1:0]  LOSS_BAD_C  = BAD_W'(LOSS_BAD);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  lfsr_state_e        state_r, state_s;
  logic [LFSR_W-1:0]  shreg_r, shreg_s;
  logic [FILL_W-1:0]  fill_r, fill_s;
  logic [GOOD_W-1:0]  good_r, good_s, good_inc_s;
  logic [BAD_W-1:0]   bad_r, bad_s, bad_inc_s;
  logic [CNT_W-1:0]   err_count_r, err_count_s;
  logic               locked_r, locked_s;
  logic               err_pulse_r, err_pulse_s;
  logic               lock_lost_r, lock_lost_s;
  logic               pred_s;
  logic               mismatch_s;

  // Next-state, window and counter logic; nothing moves without in_valid.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    fill_s      = fill_r;
    good_s      = good_r;
    bad_s       = bad_r;
    err_count_s = err_count_r;
    err_pulse_s = 1'b0;
    lock_lost_s = 1'b0;

    pred_s     = shreg_r[TAP_A] ^ shreg_r[TAP_B] ^ shreg_r[TAP_C] ^ shreg_r[TAP_D];
    mismatch_s = in_bit ^ pred_s;
    good_inc_s = good_r + 8'd1;
    bad_inc_s  = bad_r + 4'd1;

    if (in_valid) begin
      case (state_r)
        ST_HUNT: begin
          shreg_s = {in_bit, shreg_r[LFSR_W-1:1]};
          if (fill_r == FILL_LAST) begin
            state_s = ST_VERIFY;
            fill_s  = 5'd0;
            good_s  = 8'd0;
          end else begin
            fill_s = fill_r + 5'd1;
          end
        end
        ST_VERIFY: begin
          shreg_s = {in_bit, shreg_r[LFSR_W-1:1]};
          // An all-zero window predicts zeros forever, so it never proves lock.
          if ((shreg_r == {LFSR_W{1'b0}}) || mismatch_s) begin
            state_s = ST_HUNT;
            fill_s  = 5'd0;
          end else if (good_inc_s == LOCK_GOOD_C) begin
            state_s = ST_LOCKED;
            good_s  = 8'd0;
            bad_s   = 4'd0;
          end else begin
            good_s = good_inc_s;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the local sequence is self-sustaining, errors never enter it.
          shreg_s = {pred_s, shreg_r[LFSR_W-1:1]};
          if (mismatch_s) begin
            err_pulse_s = 1'b1;
            if (err_count_r != CNT_MAX) begin
              err_count_s = err_count_r + 16'd1;
            end else begin
              err_count_s = err_count_r;
            end
            if (bad_inc_s == LOSS_BAD_C) begin
              state_s     = ST_HUNT;
              lock_lost_s = 1'b1;
              fill_s      = 5'd0;
              bad_s       = 4'd0;
            end else begin
              bad_s = bad_inc_s;
            end
          end else begin
            bad_s = 4'd0;
          end
        end
        default: begin
          state_s = ST_HUNT;
          fill_s  = 5'd0;
          good_s  = 8'd0;
          bad_s   = 4'd0;
        end
      endcase
    end else begin
      shreg_s = shreg_r;
    end

    if (clear_err) begin
      err_count_s = 16'd0;
    end else begin
      err_count_s = err_count_s;
    end

    locked_s = (state_s == ST_LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HUNT;
      shreg_r     <= {LFSR_W{1'b0}};
      fill_r      <= 5'd0;
      good_r      <= 8'd0;
      bad_r       <= 4'd0;
      err_count_r <= 16'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      fill_r      <= fill_s;
      good_r      <= good_s;
      bad_r       <= bad_s;
      err_count_r <= err_count_s;
      locked_r    <= locked_s;
      err_pulse_r <= err_pulse_s;
      lock_lost_r <= lock_lost_s;
    end
  end

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;
  assign lock_lost = lock_lost_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a reset/idle vector table followed by
// hand-written sequences, each step pushing its expectation to a scoreboard
// queue that is popped and compared one edge later.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        clear_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        lock_lost;

  typedef struct packed {
    logic        lk;
    logic        pulse;
    logic        lost;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic  r;
    logic  v;
    logic  b;
    logic  c;
    exp_t  e;
  } vec_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [19:0] gen;

  lfsr_checker #(.LOCK_GOOD(32), .LOSS_BAD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .lock_lost (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic lk, input logic pu, input logic lo, input logic [15:0] c);
    exp_t e;
    e.lk = lk; e.pulse = pu; e.lost = lo; e.cnt = c;
    return e;
  endfunction

  // Reference generator: emits oldest window bit, feeds back the recurrence.
  task automatic gen_bit(output logic b);
    b   = gen[0];
    gen = {gen[15] ^ gen[11] ^ gen[7] ^ gen[0], gen[19:1]};
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic c,
                      input exp_t e, input string nm);
    exp_t got, want;
    rst = r; in_valid = v; in_bit = b; clear_err = c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {locked, err_pulse, lock_lost, err_count};
    want = sb_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got locked=%b pulse=%b lost=%b cnt=%0d, want locked=%b pulse=%b lost=%b cnt=%0d",
               nm, $time, got.lk, got.pulse, got.lost, got.cnt,
               want.lk, want.pulse, want.lost, want.cnt);
    end
  endtask

  initial begin
    vec_t  tbl[6];
    logic  b;
    int    vcnt;
    logic  v;

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0;
    gen = 20'h00001;

    // Reset state, idle cycles and clear while nothing is counted.
    tbl[0] = '{r:1'b1, v:1'b0, b:1'b0, c:1'b0, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[1] = '{r:1'b0, v:1'b0, b:1'b1, c:1'b0, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[2] = '{r:1'b0, v:1'b0, b:1'b1, c:1'b1, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[3] = '{r:1'b0, v:1'b1, b:1'b1, c:1'b0, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[4] = '{r:1'b1, v:1'b1, b:1'b1, c:1'b1, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[5] = '{r:1'b1, v:1'b0, b:1'b0, c:1'b0, e:mk(1'b0, 1'b0, 1'b0, 16'd0)};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].e, "vec_table");
    end

    // Continuous stream from seed 1: lock after 20 fill + 32 verify bits.
    gen = 20'h00001;
    for (int i = 0; i < 10000; i++) begin
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(i >= 51, 1'b0, 1'b0, 16'd0), "lock_stream");
    end

    // Single inverted bit: one error, lock held, flywheel stays aligned.
    gen_bit(b);
    step(1'b0, 1'b1, ~b, 1'b0, mk(1'b1, 1'b1, 1'b0, 16'd1), "single_err");
    for (int i = 0; i < 3; i++) begin
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(1'b1, 1'b0, 1'b0, 16'd1), "single_err_after");
    end

    // Clear on an idle cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 16'd0), "clear_idle");

    // Four consecutive errors: loss of lock on the fourth, count held.
    for (int k = 1; k <= 4; k++) begin
      gen_bit(b);
      step(1'b0, 1'b1, ~b, 1'b0, mk(k < 4, 1'b1, k == 4, 16'(k)), "burst_err");
    end
    for (int j = 0; j < 60; j++) begin
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(j >= 51, 1'b0, 1'b0, 16'd4), "relock");
    end

    // All-zero input never locks.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0), "zero_rst");
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0), "zero_feed");
    end

    // Gapped stream: lock counted in valid bits only; garbage on idle cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0), "gap_rst");
    gen  = 20'h00001;
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) >= 3);
      if (v) begin
        gen_bit(b);
        vcnt++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(1'b0, v, b, 1'b0, mk(vcnt >= 52, 1'b0, 1'b0, 16'd0), "gap_stream");
    end

    // Count to 5, clear together with a mismatch, lose lock, reset mid-VERIFY.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0), "clr_rst");
    gen = 20'h00001;
    for (int i = 0; i < 52; i++) begin
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(i >= 51, 1'b0, 1'b0, 16'd0), "clr_lock");
    end
    for (int k = 1; k <= 5; k++) begin
      gen_bit(b);
      step(1'b0, 1'b1, ~b, 1'b0, mk(1'b1, 1'b1, 1'b0, 16'(k)), "clr_err_bit");
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(1'b1, 1'b0, 1'b0, 16'(k)), "clr_good_bit");
    end
    gen_bit(b);
    step(1'b0, 1'b1, ~b, 1'b1, mk(1'b1, 1'b1, 1'b0, 16'd0), "clear_vs_err");
    for (int k = 1; k <= 3; k++) begin
      gen_bit(b);
      step(1'b0, 1'b1, ~b, 1'b0, mk(k < 3, 1'b1, k == 3, 16'(k)), "post_clear_err");
    end
    for (int i = 0; i < 25; i++) begin
      gen_bit(b);
      step(1'b0, 1'b1, b, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd3), "hunt_verify");
    end
    gen_bit(b);
    step(1'b1, 1'b1, b, 1'b1, mk(1'b0, 1'b0, 1'b0, 16'd0), "rst_mid_verify");
    gen_bit(b);
    step(1'b0, 1'b1, b, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0), "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
